mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle main controller for the 32-bit MIPS subset datapath. It is the producer side of the ALU interface: it drives the 2-bit ALU opcode (00 add, 01 sub, 10 or, 11 yields 0) and consumes the ALU `zero` flag.
- Moore FSM, decoding opcode/funct from the instruction register.
- Sequences fetch, decode, execute, memory and writeback, and drives all datapath mux selects and write enables.
- Supported instructions: addu, subu, ori, lw, sw, beq, lui, j.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26]; stable from end of FETCH until next FETCH
- funct  input  6  IR[5:0]
- zero  input  1  ALU equality flag (A==B), combinational from datapath
- pc_write  output  1  PC register write enable
- pc_src  output  2  PC next: 00 ALU result, 01 ALUOut register, 10 {PC[31:28],IR[25:0],2'b00}
- ir_write  output  1  IR write enable; MDR written every cycle by datapath
- mem_write  output  1  data memory write enable
- reg_write  output  1  GRF write enable
- reg_dst  output  2  GRF write addr: 00 rt, 01 rd
- mem_to_reg  output  2  GRF write data: 00 ALUOut, 01 MDR
- alu_src_a  output  1  ALU A: 0 PC, 1 register A (rs)
- alu_src_b  output  2  ALU B: 00 register B (rt), 01 constant 4, 10 ext(imm), 11 sign-ext(imm)<<2
- ext_op  output  2  immediate extender: 00 zero-ext, 01 sign-ext, 10 imm<<16
- alu_op  output  2  ALU opcode: 00 add, 01 sub, 10 or
- state  output  4  current state encoding (debug)

Behaviour:
- Output defaults in every state unless listed: all enables 0; all selects 0; ext_op 01.
- State encodings and per-state outputs:
  - 0 FETCH: ir_write=1, pc_write=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_op=00 -> DECODE
  - 1 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; precomputes branch target into ALUOut. Next state:
    - lw(100011) or sw(101011) -> MEM_ADDR
    - R-type(000000) with funct addu(100001) or subu(100011) -> R_EXEC
    - beq(000100) -> BRANCH
    - ori(001101) -> ORI_EXEC
    - lui(001111) -> LUI_EXEC
    - j(000010) -> JUMP
    - anything else, including all-zero nop -> FETCH, no writes
  - 2 MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=01, alu_op=00 -> MEM_READ if lw, MEM_WRITE if sw
  - 3 MEM_READ: no enables -> MEM_WB
  - 4 MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH
  - 5 MEM_WRITE: mem_write=1 -> FETCH
  - 6 R_EXEC: alu_src_a=1, alu_src_b=00; alu_op=00 for addu, 01 for subu -> R_WB
  - 7 R_WB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH
  - 8 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero -> FETCH
  - 9 ORI_EXEC: alu_src_a=1, alu_src_b=10, ext_op=00, alu_op=10 -> IMM_WB
  - 10 LUI_EXEC: alu_src_a=1, alu_src_b=10, ext_op=10, alu_op=00. rs is $0 for lui, so the result is imm<<16. -> IMM_WB
  - 11 IMM_WB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH
  - 12 JUMP: pc_write=1, pc_src=10 -> FETCH
  - 13-15: unused; treated as FETCH outputs suppressed; next state FETCH
- Outputs are purely a function of state, plus funct in R_EXEC and zero in BRANCH.
- pc_write in BRANCH follows zero combinationally within the same cycle.
- Cycle counts, FETCH to next FETCH:
  - lw 5
  - sw, addu, subu, ori, lui 4
  - beq, j 3
  - unsupported 2
- Reset:
  - While reset=1, pc_write, ir_write, mem_write and reg_write are forced 0; selects follow the FETCH values.
  - On a clock edge with reset=1, state becomes FETCH from any state, including mid-instruction. No write enable of the aborted instruction ever asserts afterwards.
  - First FETCH with enables active is the first cycle after reset deasserts.
  - state output resets to 0.
- opcode/funct are sampled only in DECODE, MEM_ADDR and R_EXEC. Changes in other states have no effect.

Test Plan:
- Reset held 2 cycles, then released:
  - state=0 during reset with pc_write=ir_write=0
  - cycle after release: pc_write=1, ir_write=1, alu_src_b=01
- lw (opcode 100011): state sequence 0,1,2,3,4,0. In state 4: reg_write=1, mem_to_reg=01, reg_dst=00. mem_write never 1.
- addu (000000/100001), then subu (000000/100011):
  - sequence 0,1,6,7,0 for each
  - alu_op=00 in state 6 for addu, 01 for subu
  - reg_dst=01 in state 7
- beq:
  - zero=1 in state 8 -> pc_write=1, pc_src=01, alu_op=01
  - repeat with zero=0 -> pc_write=0
  - both return to FETCH next cycle
- ori, lui, j:
  - ori: ext_op=00, alu_op=10 in state 9
  - lui: ext_op=10 in state 10
  - both reach state 11 with reg_write=1
  - j: state 12, pc_write=1, pc_src=10
- Opcode 111111 and nop (0x00000000): sequence 0,1,0 with no enables in DECODE.
- Reset asserted in state 3 of lw: next state 0, and reg_write never asserts for that lw.

Source files
------------

// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl : multi-cycle main controller for the 32-bit MIPS subset datapath.
//
// Moore FSM that walks each instruction through fetch, decode, execute,
// memory and writeback. It drives every datapath mux select and write
// enable, and acts as the producer side of the ALU interface. Control words
// are a function of the current state only. The exceptions are alu_op in
// R_EXEC, which follows funct, and pc_write in BRANCH, which follows zero
// combinationally.
//
// Supported instructions: addu, subu, ori, lw, sw, beq, lui, j. Any other
// encoding, including the all-zero nop, returns to FETCH straight from
// DECODE without asserting a write.
// ---------------------------------------------------------------------------
module mc_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] ext_op,
   output logic [1:0] alu_op,
   output logic [3:0] state
);

   // -----------------------------------------------------------------------
   // State encoding. The values are visible on the debug port, so they are
   // fixed. Codes 13-15 are never entered; they recover to FETCH.
   // -----------------------------------------------------------------------
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_ORI_EXEC  = 4'd9,
      S_LUI_EXEC  = 4'd10,
      S_IMM_WB    = 4'd11,
      S_JUMP      = 4'd12
   } state_t;

   // Instruction field encodings
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;

   // Mux-select encodings
   localparam logic [1:0] PC_ALU     = 2'b00;  // ALU result (PC+4)
   localparam logic [1:0] PC_ALUOUT  = 2'b01;  // branch target held in ALUOut
   localparam logic [1:0] PC_JUMP    = 2'b10;  // {PC[31:28], IR[25:0], 2'b00}
   localparam logic [1:0] DST_RT     = 2'b00;
   localparam logic [1:0] DST_RD     = 2'b01;
   localparam logic [1:0] WD_ALUOUT  = 2'b00;
   localparam logic [1:0] WD_MDR     = 2'b01;
   localparam logic [1:0] B_REG      = 2'b00;
   localparam logic [1:0] B_FOUR     = 2'b01;
   localparam logic [1:0] B_IMM      = 2'b10;
   localparam logic [1:0] B_IMM_SL2  = 2'b11;
   localparam logic [1:0] EXT_ZERO   = 2'b00;
   localparam logic [1:0] EXT_SIGN   = 2'b01;
   localparam logic [1:0] EXT_LUI    = 2'b10;
   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_SUB    = 2'b01;
   localparam logic [1:0] ALU_OR     = 2'b10;

   // Complete control word for one cycle
   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] ext_op;
      logic [1:0] alu_op;
   } ctrl_t;

   state_t r_state;
   ctrl_t  w_ctrl;
   logic   w_is_addu;
   logic   w_is_subu;
   logic   w_is_rtype_ok;

   assign w_is_addu     = (funct == FN_ADDU);
   assign w_is_subu     = (funct == FN_SUBU);
   assign w_is_rtype_ok = (opcode == OP_RTYPE) && (w_is_addu || w_is_subu);

   // Quiet control word: no enables, every select at 0, sign extension.
   function automatic ctrl_t quiet_ctrl();
      ctrl_t c;
      c            = '0;
      c.ext_op     = EXT_SIGN;
      return c;
   endfunction

   // FETCH selects with every enable suppressed. This word is used during
   // reset and in the unused state codes.
   function automatic ctrl_t idle_ctrl();
      ctrl_t c;
      c            = quiet_ctrl();
      c.pc_src     = PC_ALU;
      c.alu_src_a  = 1'b0;
      c.alu_src_b  = B_FOUR;
      c.alu_op     = ALU_ADD;
      return c;
   endfunction

   // State register with next-state decode. opcode and funct are only looked
   // at in DECODE, MEM_ADDR and R_EXEC.
   // NOTE: sequential state uses non-blocking (<=) assignments so every flop
   // samples the values from before the edge, whatever the statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:     r_state <= S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_LW,
                  OP_SW:    r_state <= S_MEM_ADDR;
                  OP_RTYPE: r_state <= w_is_rtype_ok ? S_R_EXEC : S_FETCH;
                  OP_BEQ:   r_state <= S_BRANCH;
                  OP_ORI:   r_state <= S_ORI_EXEC;
                  OP_LUI:   r_state <= S_LUI_EXEC;
                  OP_J:     r_state <= S_JUMP;
                  default:  r_state <= S_FETCH;
               endcase
            end
            S_MEM_ADDR: begin
               if (opcode == OP_LW)      r_state <= S_MEM_READ;
               else if (opcode == OP_SW) r_state <= S_MEM_WRITE;
               else                      r_state <= S_FETCH;
            end
            S_MEM_READ:  r_state <= S_MEM_WB;
            S_MEM_WB:    r_state <= S_FETCH;
            S_MEM_WRITE: r_state <= S_FETCH;
            S_R_EXEC:    r_state <= S_R_WB;
            S_R_WB:      r_state <= S_FETCH;
            S_BRANCH:    r_state <= S_FETCH;
            S_ORI_EXEC:  r_state <= S_IMM_WB;
            S_LUI_EXEC:  r_state <= S_IMM_WB;
            S_IMM_WB:    r_state <= S_FETCH;
            S_JUMP:      r_state <= S_FETCH;
            default:     r_state <= S_FETCH;
         endcase
      end
   end

   // Control word decode from the current state. While reset is high, the
   // word is overridden so that no write can reach the datapath.
   // NOTE: w_ctrl gets a full default before the case, so every path assigns
   // every bit and no latch can be inferred.
   always_comb begin
      w_ctrl = quiet_ctrl();
      case (r_state)
         S_FETCH: begin
            w_ctrl           = idle_ctrl();
            w_ctrl.ir_write  = 1'b1;
            w_ctrl.pc_write  = 1'b1;
         end
         S_DECODE: begin
            // Branch target PC + (sext(imm) << 2) is precomputed into ALUOut
            w_ctrl.alu_src_a = 1'b0;
            w_ctrl.alu_src_b = B_IMM_SL2;
            w_ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_ADDR: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = B_IMM;
            w_ctrl.ext_op    = EXT_SIGN;
            w_ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_READ: begin
            // MDR captures memory data on its own; nothing to enable
         end
         S_MEM_WB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.reg_dst    = DST_RT;
            w_ctrl.mem_to_reg = WD_MDR;
         end
         S_MEM_WRITE: begin
            w_ctrl.mem_write = 1'b1;
         end
         S_R_EXEC: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = B_REG;
            w_ctrl.alu_op    = w_is_subu ? ALU_SUB : ALU_ADD;
         end
         S_R_WB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.reg_dst    = DST_RD;
            w_ctrl.mem_to_reg = WD_ALUOUT;
         end
         S_BRANCH: begin
            // Compare rs with rt. Take the ALUOut target only when equal.
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = B_REG;
            w_ctrl.alu_op    = ALU_SUB;
            w_ctrl.pc_src    = PC_ALUOUT;
            w_ctrl.pc_write  = zero;
         end
         S_ORI_EXEC: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = B_IMM;
            w_ctrl.ext_op    = EXT_ZERO;
            w_ctrl.alu_op    = ALU_OR;
         end
         S_LUI_EXEC: begin
            // rs is $0 for lui, so $0 + (imm << 16) is the result
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = B_IMM;
            w_ctrl.ext_op    = EXT_LUI;
            w_ctrl.alu_op    = ALU_ADD;
         end
         S_IMM_WB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.reg_dst    = DST_RT;
            w_ctrl.mem_to_reg = WD_ALUOUT;
         end
         S_JUMP: begin
            w_ctrl.pc_write = 1'b1;
            w_ctrl.pc_src   = PC_JUMP;
         end
         default: begin
            w_ctrl = idle_ctrl();
         end
      endcase

      if (reset) begin
         w_ctrl = idle_ctrl();
      end
   end

   assign pc_write   = w_ctrl.pc_write;
   assign pc_src     = w_ctrl.pc_src;
   assign ir_write   = w_ctrl.ir_write;
   assign mem_write  = w_ctrl.mem_write;
   assign reg_write  = w_ctrl.reg_write;
   assign reg_dst    = w_ctrl.reg_dst;
   assign mem_to_reg = w_ctrl.mem_to_reg;
   assign alu_src_a  = w_ctrl.alu_src_a;
   assign alu_src_b  = w_ctrl.alu_src_b;
   assign ext_op     = w_ctrl.ext_op;
   assign alu_op     = w_ctrl.alu_op;
   assign state      = r_state;

endmodule
